dual_slope_ctrl: RTL and testbench

- Control and counting stage of the dual-slope ADC.
- Sequences the analog switches through integrate, de-integrate and auto-zero phases.
- Counts de-integration time in a cascaded BCD counter and latches the result as packed BCD digits.
- Each latched digit feeds one downstream BCD-to-7-segment decoder instance.

---
 rtl/dual_slope_ctrl.sv | 156 +++++++++++++++
 tb/tb_dual_slope_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dual_slope_ctrl.sv
// dual_slope_ctrl: control and counting stage of a dual-slope ADC.
// Sequences the analog switches through auto-zero, integrate and
// de-integrate phases. De-integration time is counted in a cascaded BCD
// counter, and the result is latched as packed BCD digits.
//
// Parameters:
//   DIGITS    - number of BCD decades (full scale 10^DIGITS - 1)
//   AZ_CYCLES - auto-zero phase length in clock cycles (>= 1)
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   start      - conversion request, honoured only in IDLE
//   comp       - comparator, 1 = integrator not yet through zero
//   sw_in      - connect the unknown input to the integrator (INTEG)
//   sw_ref     - connect the reference to the integrator (DEINT)
//   sw_zero    - short the integrator (IDLE, ZERO)
//   busy       - high in every state except IDLE
//   done       - one-cycle pulse while a new result is being latched
//   overflow   - latched with the result; de-integration hit full scale
//   bcd_out    - latched result, digit i in bcd_out[4i+3:4i]
module dual_slope_ctrl #(
    parameter int unsigned DIGITS    = 3,
    parameter int unsigned AZ_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  comp,
    output logic                  sw_in,
    output logic                  sw_ref,
    output logic                  sw_zero,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int unsigned CW  = 4 * DIGITS;
    localparam int unsigned AZW = (AZ_CYCLES > 1) ? $clog2(AZ_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        INTEG,
        DEINT,
        LATCH,
        ZERO
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;
    logic            cnt_max;
    logic [AZW-1:0]  az_cnt;
    logic            ovf_pend;

    // Switch/busy pattern for a state: {sw_in, sw_ref, sw_zero, busy}.
    // Outputs are loaded with the pattern of the state being entered, so
    // they always reflect the state register without any input path.
    function automatic logic [3:0] outs_of(input state_t s);
        case (s)
            IDLE:    outs_of = 4'b0010;
            INTEG:   outs_of = 4'b1001;
            DEINT:   outs_of = 4'b0101;
            LATCH:   outs_of = 4'b0001;
            ZERO:    outs_of = 4'b0011;
            default: outs_of = 4'b0010;
        endcase
    endfunction

    // Cascaded decade increment: each digit wraps 9->0 and carries on.
    // All-9s increments to all-0s.
    always_comb begin
        logic carry;
        cnt_inc = cnt;
        cnt_max = 1'b1;
        carry   = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (cnt[4*i +: 4] != 4'd9) begin
                cnt_max = 1'b0;
            end
            if (carry) begin
                if (cnt[4*i +: 4] == 4'd9) begin
                    cnt_inc[4*i +: 4] = 4'd0;
                end else begin
                    cnt_inc[4*i +: 4] = cnt[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                          <= IDLE;
            cnt                            <= '0;
            az_cnt                         <= '0;
            ovf_pend                       <= 1'b0;
            {sw_in, sw_ref, sw_zero, busy} <= outs_of(IDLE);
            done                           <= 1'b0;
            overflow                       <= 1'b0;
            bcd_out                        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        state                          <= INTEG;
                        {sw_in, sw_ref, sw_zero, busy} <= outs_of(INTEG);
                    end
                end
                INTEG: begin
                    // Wrap from all-9s marks exactly 10^DIGITS cycles.
                    cnt <= cnt_inc;
                    if (cnt_max) begin
                        state                          <= DEINT;
                        {sw_in, sw_ref, sw_zero, busy} <= outs_of(DEINT);
                    end
                end
                DEINT: begin
                    if (!comp || cnt_max) begin
                        // Zero crossing takes priority over full scale.
                        state                          <= LATCH;
                        ovf_pend                       <= comp;
                        done                           <= 1'b1;
                        {sw_in, sw_ref, sw_zero, busy} <= outs_of(LATCH);
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                LATCH: begin
                    bcd_out                        <= cnt;
                    overflow                       <= ovf_pend;
                    cnt                            <= '0;
                    az_cnt                         <= '0;
                    state                          <= ZERO;
                    {sw_in, sw_ref, sw_zero, busy} <= outs_of(ZERO);
                end
                ZERO: begin
                    if (az_cnt == AZW'(AZ_CYCLES - 1)) begin
                        az_cnt                         <= '0;
                        state                          <= IDLE;
                        {sw_in, sw_ref, sw_zero, busy} <= outs_of(IDLE);
                    end else begin
                        az_cnt <= az_cnt + 1'b1;
                    end
                end
                default: begin
                    state                          <= IDLE;
                    cnt                            <= '0;
                    {sw_in, sw_ref, sw_zero, busy} <= outs_of(IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dual_slope_ctrl.sv
// tb_dual_slope_ctrl: directed, table-driven bench for dual_slope_ctrl.
// Main instance runs DIGITS=3, AZ_CYCLES=16; a second instance runs
// DIGITS=2, AZ_CYCLES=1 for randomised switch-exclusivity conversions.
module tb_dual_slope_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, comp;
    logic        sw_in, sw_ref, sw_zero, busy, done, overflow;
    logic [11:0] bcd_out;

    logic        start2, comp2;
    logic        sw_in2, sw_ref2, sw_zero2, busy2, done2, overflow2;
    logic [7:0]  bcd2;

    int checks    = 0;
    int errors    = 0;
    int excl_err  = 0;
    int nib_err   = 0;
    int phase_err = 0;
    int done_seen = 0;

    dual_slope_ctrl #(.DIGITS(3), .AZ_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .comp(comp),
        .sw_in(sw_in), .sw_ref(sw_ref), .sw_zero(sw_zero), .busy(busy),
        .done(done), .overflow(overflow), .bcd_out(bcd_out)
    );

    dual_slope_ctrl #(.DIGITS(2), .AZ_CYCLES(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .comp(comp2),
        .sw_in(sw_in2), .sw_ref(sw_ref2), .sw_zero(sw_zero2), .busy(busy2),
        .done(done2), .overflow(overflow2), .bcd_out(bcd2)
    );

    // Per-cycle invariants on both instances.
    always @(negedge clk) begin
        if (rst_n) begin
            if ($countones({sw_in, sw_ref, sw_zero}) > 1)    excl_err++;
            if ($countones({sw_in2, sw_ref2, sw_zero2}) > 1) excl_err++;
            for (int i = 0; i < 3; i++) if (bcd_out[4*i +: 4] > 4'd9) nib_err++;
            for (int i = 0; i < 2; i++) if (bcd2[4*i +: 4] > 4'd9) nib_err++;
            // IDLE: only sw_zero; all-low gap only in the done (LATCH) cycle.
            if (!busy && (!sw_zero || done)) phase_err++;
            if (busy && !sw_in && !sw_ref && !sw_zero && !done) phase_err++;
            if (!busy2 && (!sw_zero2 || done2)) phase_err++;
            if (busy2 && !sw_in2 && !sw_ref2 && !sw_zero2 && !done2) phase_err++;
            if (done) done_seen++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          k;        // comp=1 cycles in DEINT before comp=0
        bit          full;     // hold comp=1 through DEINT
        logic [11:0] exp_bcd;
        bit          exp_ovf;
        int          exp_ref;  // sw_ref high cycles
    } vec_t;

    vec_t vt[10];

    task automatic conv(input vec_t v, input bit hold_start);
        int n_in, n_ref, n_done, n_tail, guard;
        bit seen_done, hold_bad;
        logic [11:0] prev;
        n_in = 0; n_ref = 0; n_done = 0; n_tail = 0; guard = 0;
        seen_done = 0; hold_bad = 0;
        prev = bcd_out;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = hold_start;
        while (guard < 3000) begin
            if (sw_in)  n_in++;
            if (sw_ref) n_ref++;
            if (done)   n_done++;
            if (seen_done && busy) n_tail++;
            if (!seen_done && bcd_out != prev) hold_bad = 1;
            if (done) seen_done = 1;
            if (seen_done && !busy) break;
            comp = sw_ref ? (v.full || (n_ref - 1) < v.k) : 1'($urandom);
            @(negedge clk);
            guard++;
        end
        chk("finished", int'(seen_done && !busy), 1);
        chk("sw_in_cycles", n_in, 1000);
        chk("sw_ref_cycles", n_ref, v.exp_ref);
        chk("done_pulses", n_done, 1);
        chk("busy_after_done", n_tail, 16);
        chk("bcd_held_until_latch", int'(hold_bad), 0);
        chk("bcd_out", int'(bcd_out), int'(v.exp_bcd));
        chk("overflow", int'(overflow), int'(v.exp_ovf));
    endtask

    initial begin
        vec_t hv;
        int   d0;
        rst_n = 1'b0; start = 1'b0; comp = 1'b0; start2 = 1'b0; comp2 = 1'b0;
        vt[0] = '{437, 1'b0, 12'h437, 1'b0, 438};
        vt[1] = '{0,   1'b0, 12'h000, 1'b0, 1};
        vt[2] = '{99,  1'b0, 12'h099, 1'b0, 100};
        vt[3] = '{100, 1'b0, 12'h100, 1'b0, 101};
        vt[4] = '{109, 1'b0, 12'h109, 1'b0, 110};
        vt[5] = '{110, 1'b0, 12'h110, 1'b0, 111};
        vt[6] = '{0,   1'b1, 12'h999, 1'b1, 1000};
        vt[7] = '{12,  1'b0, 12'h012, 1'b0, 13};
        vt[8] = '{999, 1'b0, 12'h999, 1'b0, 1000};
        vt[9] = '{0,   1'b1, 12'h999, 1'b1, 1000};

        repeat (3) @(negedge clk);
        chk("reset_sw_zero", int'(sw_zero), 1);
        chk("reset_sw_in", int'(sw_in), 0);
        chk("reset_sw_ref", int'(sw_ref), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_overflow", int'(overflow), 0);
        chk("reset_bcd", int'(bcd_out), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) conv(vt[i], 1'b0);

        // start held high: ignored mid-conversion, then one IDLE cycle gap.
        hv = '{0, 1'b1, 12'h999, 1'b1, 1000};
        conv(vt[0], 1'b0);
        conv(hv, 1'b1);
        @(negedge clk);
        chk("back_to_back_busy", int'(busy), 1);
        chk("back_to_back_sw_in", int'(sw_in), 1);

        // Reset mid-INTEG of the back-to-back conversion.
        repeat (100) @(negedge clk);
        start = 1'b0;
        chk("mid_integ_sw_in", int'(sw_in), 1);
        d0 = done_seen;
        rst_n = 1'b0;
        #1;
        chk("midrst_sw_zero", int'(sw_zero), 1);
        chk("midrst_sw_in", int'(sw_in), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_bcd", int'(bcd_out), 0);
        chk("midrst_overflow", int'(overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (1200) @(negedge clk);
        chk("midrst_no_done", done_seen - d0, 0);
        chk("midrst_idle", int'(busy), 0);
        chk("midrst_bcd_after", int'(bcd_out), 0);

        // Randomised conversions on the small instance.
        for (int c = 0; c < 50; c++) begin
            int k, n_in, n_ref, n_tail, guard, exp_ref;
            bit full, seen_done;
            logic [7:0] exp_bcd;
            k = int'($urandom_range(0, 99));
            full = ($urandom_range(0, 7) == 0);
            exp_bcd = full ? 8'h99 : {4'(k / 10), 4'(k % 10)};
            exp_ref = full ? 100 : k + 1;
            n_in = 0; n_ref = 0; n_tail = 0; guard = 0; seen_done = 0;
            @(negedge clk); start2 = 1'b1;
            @(negedge clk); start2 = 1'b0;
            while (guard < 500) begin
                if (sw_in2)  n_in++;
                if (sw_ref2) n_ref++;
                if (seen_done && busy2) n_tail++;
                if (done2) seen_done = 1;
                if (seen_done && !busy2) break;
                comp2 = sw_ref2 ? (full || (n_ref - 1) < k) : 1'($urandom);
                @(negedge clk);
                guard++;
            end
            chk("d2_finished", int'(seen_done && !busy2), 1);
            chk("d2_sw_in_cycles", n_in, 100);
            chk("d2_sw_ref_cycles", n_ref, exp_ref);
            chk("d2_busy_after_done", n_tail, 1);
            chk("d2_bcd", int'(bcd2), int'(exp_bcd));
            chk("d2_overflow", int'(overflow2), int'(full));
        end

        chk("switch_exclusive", excl_err, 0);
        chk("nibbles_in_range", nib_err, 0);
        chk("phase_consistency", phase_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
